seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal >= GUARD+2).
REQ-003 SHALL have parameter GUARD, default 2, anode-off cycles at the start of each slot (anti-ghosting).
REQ-004 SHALL have parameter AN_ACTIVE_LOW, default 1; 1 = anode asserted low, 0 = asserted high.
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port load, input, 1, capture value_in/dp_in into the shadow register.
REQ-008 SHALL have port value_in, input, 4*NUM_DIGITS, hex nibbles; nibble 0 is the rightmost digit.
REQ-009 SHALL have port dp_in, input, NUM_DIGITS, per-digit decimal point, 1 = lit.
REQ-010 SHALL have port blank, input, 1, 1 = all digits dark.
REQ-011 SHALL have port seg_out, output, 7, segments a..g on bits 6..0, active-low.
REQ-012 SHALL have port dp_out, output, 1, decimal point, active-low.
REQ-013 SHALL have port an_out, output, NUM_DIGITS, digit enables, polarity per AN_ACTIVE_LOW.

Function
REQ-014 SHALL capture value_in and dp_in into the shadow register on any rising clk edge where load=1; display data SHALL come only from the shadow register (no tearing).
REQ-015 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; on wrap, the digit index SHALL advance by one.
REQ-016 SHALL wrap the digit index from NUM_DIGITS-1 to 0.
REQ-017 SHALL implement FSM states GUARD_S and DRIVE_S; it SHALL enter GUARD_S on each index advance.
REQ-018 SHALL hold GUARD_S for GUARD cycles with all anodes inactive and seg_out=7'h7F, dp_out=1; it SHALL then enter DRIVE_S until the next index advance.
REQ-019 SHALL in DRIVE_S assert exactly one anode, bit [index], and drive seg_out with the decoded nibble and dp_out=~dp_in_shadow[index].
REQ-020 SHALL decode digits as 0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111 8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000.
REQ-021 SHALL register all outputs; a shadow-register change SHALL appear on seg_out one cycle after capture if in DRIVE_S.
REQ-022 SHALL, while blank=1, force anodes inactive, seg_out=7'h7F and dp_out=1 from the next edge; the prescaler and index SHALL keep running.
REQ-023 SHALL, when load coincides with an index advance, use the newly captured data for the new slot's first DRIVE_S cycle.
REQ-024 SHALL, when NUM_DIGITS=1, hold the index at 0 while still applying the GUARD gap each slot.

Reset
REQ-025 SHALL, on rst_n=0 (asynchronous), clear the prescaler, index, and shadow register to 0, set the FSM to GUARD_S, anodes inactive, seg_out=7'h7F, dp_out=1.
REQ-026 SHALL, after rst_n deasserts mid-operation, restart scanning at index 0 with a full GUARD gap.

Configuration
REQ-027 SHALL, with LEADING_ZERO_BLANK_EN defined, show seg_out=7'h7F (anode still asserted, dp per dp_in) for every digit above the most significant nonzero nibble; digit 0 SHALL always display.
REQ-028 SHALL, without LEADING_ZERO_BLANK_EN, display every digit including leading zeros.

Structure
REQ-029 SHALL place the 16-entry segment code table, SEG_OFF=7'h7F, and the FSM state typedef in the shared package seg7_pkg.
REQ-030 SHALL implement the nibble decoder as one combinational sub-module, seg7_nibble_decode; the scanner instantiates it once on the muxed nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, AN_ACTIVE_LOW=1)
REQ-031 SHALL cover reset then load value_in=16'h12AF: per slot, an_out=1111 for 2 cycles then 1110/1101/1011/0111 for 6 cycles with seg F=0111000, A=0001000, 2=0010010, 1=1001111.
REQ-032 SHALL cover dp_in=4'b0100: dp_out=0 only while an_out=1011.
REQ-033 SHALL cover load=1 on the wrap edge from index 3 to 0 with value_in=16'h0005: the first DRIVE_S cycle of digit 0 shows 0100100.
REQ-034 SHALL cover blank=1 for 20 cycles: an_out=1111, seg_out=7'h7F throughout; index position afterwards matches free-running count.
REQ-035 SHALL cover LEADING_ZERO_BLANK_EN with value 16'h0030: digits 3,2 show 7'h7F, digit 1 shows 0000110, digit 0 shows 0000001; without the macro, digits 3,2 show 0000001.
REQ-036 SHALL cover rst_n asserted mid-DRIVE_S of digit 2: outputs go off asynchronously; after release, scan restarts at an_out=1110 after 2 GUARD cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: segment code table,
// the all-dark segment pattern and the scan FSM state type.
package seg7_pkg;

    typedef enum logic {
        GUARD_S = 1'b0,
        DRIVE_S = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low codes, segments a..g on bits 6..0, indexed by nibble value
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/seg7_nibble_decode.sv
// Combinational hex nibble to active-low seven-segment code lookup.
module seg7_nibble_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment display driver with anti-ghosting guard gap.
// Optional build macro LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero nibble.
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int GUARD         = 2,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    // GUARD is expected to be at least 1: the last guard cycle is the slot's presc GUARD-1
    localparam logic [PRESC_W-1:0]    GUARD_LAST = PRESC_W'(GUARD - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    scan_state_t             state;
    logic [4*NUM_DIGITS-1:0] value_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;

    logic       wrap;
    logic       drive_nxt;
    logic [3:0] nib;
    logic       dp_cur;
    logic [6:0] seg_dec;
    logic       lz_blank;

    assign wrap      = (presc == PRESC_LAST);
    assign drive_nxt = !wrap && ((state == DRIVE_S) || (presc == GUARD_LAST));

    always_comb begin
        nib    = 4'h0;
        dp_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib    = value_sh[i*4 +: 4];
                dp_cur = dp_sh[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is dark while everything at or above it is zero
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (value_sh[i*4 +: 4] == 4'h0);
            if (idx == IDX_W'(i)) lz_blank = zero_above;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg7_nibble_decode u_decode (
        .nibble (nib),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            idx      <= '0;
            state    <= GUARD_S;
            value_sh <= '0;
            dp_sh    <= '0;
            an_out   <= AN_OFF;
            seg_out  <= SEG_OFF;
            dp_out   <= 1'b1;
        end else begin
            if (load) begin
                value_sh <= value_in;
                dp_sh    <= dp_in;
            end

            if (wrap) begin
                presc <= '0;
                idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                state <= GUARD_S;
            end else begin
                presc <= presc + PRESC_W'(1);
                if (state == GUARD_S && presc == GUARD_LAST) state <= DRIVE_S;
            end

            // Outputs follow the state being entered, so they are registered with it
            if (drive_nxt && !blank) begin
                an_out  <= AN_OFF ^ (NUM_DIGITS'(1) << idx);
                seg_out <= lz_blank ? SEG_OFF : seg_dec;
                dp_out  <= ~dp_cur;
            end else begin
                an_out  <= AN_OFF;
                seg_out <= SEG_OFF;
                dp_out  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 8-cycle slots, 2-cycle guard, active-low anodes).
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: t = clock edges since reset released
    int          t = 0;
    logic [15:0] sh_val = 16'h0;
    logic [3:0]  sh_dp = 4'h0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic [6:0]  seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [6:0]  lz_upper;

    seven_segment_scanner #(
        .NUM_DIGITS    (4),
        .REFRESH_DIV   (8),
        .GUARD         (2),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .blank    (blank),
        .seg_out  (seg_out),
        .dp_out   (dp_out),
        .an_out   (an_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t);
        end
    endtask

    task automatic goto(input int target);
        int n = 0;
        while (t != target && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("goto_bound", t, target);
    endtask

    // Behavioural model: slot position is pure arithmetic on elapsed cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; sh_val = 16'h0; sh_dp = 4'h0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            int p, slot, digit;
            t = t + 1;
            p = t % 8;
            slot = (t / 8) % 4;
            if (blank || p < 2) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                digit = (sh_val >> (4 * slot)) & 15;
                exp_an = ~(4'b0001 << slot);
                exp_seg = seg_tab[digit];
`ifdef LEADING_ZERO_BLANK_EN
                if (slot > 0 && (sh_val >> (4 * slot)) == 0) exp_seg = 7'h7F;
`endif
                exp_dp = ~sh_dp[slot];
            end
            if (load) begin
                sh_val = value_in;
                sh_dp = dp_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("scan", {21'h0, an_out, seg_out, dp_out}, {21'h0, exp_an, exp_seg, exp_dp});
    end

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        lz_upper = 7'h7F;
`else
        lz_upper = 7'b0000001;
`endif
        repeat (3) @(negedge clk);
        check("rst_an", an_out, 4'b1111);
        check("rst_seg", seg_out, 7'h7F);
        check("rst_dp", dp_out, 1'b1);
        chk_en = 1'b1;

        rst_n = 1'b1; load = 1'b1; value_in = 16'h12AF; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        check("guard_t1_an", an_out, 4'b1111);
        goto(2);
        check("d0_an", an_out, 4'b1110);
        check("d0_seg", seg_out, 7'b0111000);
        check("d0_dp", dp_out, 1'b1);
        goto(9);
        check("guard_t9_an", an_out, 4'b1111);
        goto(10);
        check("d1_an", an_out, 4'b1101);
        check("d1_seg", seg_out, 7'b0001000);
        goto(18);
        check("d2_an", an_out, 4'b1011);
        check("d2_seg", seg_out, 7'b0010010);
        check("d2_dp", dp_out, 1'b0);
        goto(26);
        check("d3_an", an_out, 4'b0111);
        check("d3_seg", seg_out, 7'b1001111);
        check("d3_dp", dp_out, 1'b1);

        goto(31);
        load = 1'b1; value_in = 16'h0005; dp_in = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        check("wrap_guard_an", an_out, 4'b1111);
        goto(34);
        check("wrap_load_an", an_out, 4'b1110);
        check("wrap_load_seg", seg_out, 7'b0100100);

        goto(40);
        blank = 1'b1;
        goto(50);
        check("blank_an", an_out, 4'b1111);
        check("blank_seg", seg_out, 7'h7F);
        goto(60);
        blank = 1'b0;
        @(negedge clk);
        check("post_blank_an", an_out, 4'b0111);

        goto(63);
        load = 1'b1; value_in = 16'h0030;
        @(negedge clk);
        load = 1'b0;
        goto(66);
        check("lz_d0_seg", seg_out, 7'b0000001);
        goto(74);
        check("lz_d1_seg", seg_out, 7'b0000110);
        goto(82);
        check("lz_d2_seg", seg_out, lz_upper);
        check("lz_d2_an", an_out, 4'b1011);
        goto(90);
        check("lz_d3_seg", seg_out, lz_upper);

        goto(116);
        check("pre_rst_an", an_out, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an", an_out, 4'b1111);
        check("async_rst_seg", seg_out, 7'h7F);
        check("async_rst_dp", dp_out, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_t1_an", an_out, 4'b1111);
        @(negedge clk);
        check("restart_t2_an", an_out, 4'b1110);
        check("restart_t2_seg", seg_out, 7'b0000001);
        goto(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
